// File: rtl/pc_pkg.sv
// Shared definitions for the instruction-address generator.
//   pc_state_t    : DIS (fetch disabled), RUN (normal), HOLD (redirect pending)
//   ChipEnable / ChipDisable : instruction-memory chip enable levels
//   RstEnable     : active level of rst
//   InstAddrBusW  : default instruction address bus width
package pc_pkg;

  typedef enum logic [1:0] {DIS, RUN, HOLD} pc_state_t;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam int   InstAddrBusW = 32;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect source arbiter (purely combinational).
//   flush, flush_pc       : exception/ERET redirect, always wins
//   branch_flag, branch_pc: ID-stage branch, only honoured while not stalled
//   stall0                : PC hold (stall[0])
//   redirect              : some redirect is selected this cycle
//   target                : selected target with ALIGN_BITS cleared
//   raw_misalign          : selected raw target had nonzero low bits
module pc_redirect_arb #(
  parameter int ADDR_W     = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic              stall0,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              raw_misalign
);

  // Built by shift so ALIGN_BITS == 0 yields an all-zero mask.
  localparam logic [ADDR_W-1:0] AMASK = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

  logic [ADDR_W-1:0] raw;

  assign redirect     = flush | (branch_flag & ~stall0);
  assign raw          = flush ? flush_pc : branch_pc;
  assign target       = raw & ~AMASK;
  assign raw_misalign = redirect & (|(raw & AMASK));

endmodule

// File: rtl/pc_gen.sv
// Instruction-address generator for the IF stage.
//   clk, rst     : clock, synchronous active-high reset
//   stall[0]     : PC hold (other bits ignored here)
//   flush/_pc    : highest-priority redirect
//   branch_*     : branch redirect, ignored while stalled
//   req_ready    : instruction memory accepts the current request
//   pc, ce       : fetch address and chip enable (registered)
//   req_valid    : fetch request valid (combinational)
//   fetch_kill   : the fetch accepted this cycle is stale, IF/ID drops it
//   misalign     : one-cycle pulse after a misaligned redirect target
// A redirect arriving while a request is stuck (valid, not ready) is parked
// in pend_pc (state HOLD == pending valid) so pc stays stable until the
// handshake completes or the request is withdrawn by a stall.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = InstAddrBusW,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                STEP       = 4,
  parameter int                ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              req_valid,
  output logic              fetch_kill,
  output logic              misalign
);

  pc_state_t         state;
  logic [ADDR_W-1:0] pend_pc, pend_nxt, target;
  logic              pend_flush, pend_flush_nxt;
  logic              redirect, raw_misalign, fire;
  logic              unused_stall;

  assign unused_stall = ^stall[5:1];

  pc_redirect_arb #(.ADDR_W(ADDR_W), .ALIGN_BITS(ALIGN_BITS)) u_arb (
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_pc    (branch_pc),
    .stall0       (stall[0]),
    .redirect     (redirect),
    .target       (target),
    .raw_misalign (raw_misalign)
  );

  assign req_valid  = ce & ~stall[0] & (state != DIS);
  assign fire       = req_valid & req_ready;
  assign fetch_kill = fire & ((state == HOLD) | ((state == RUN) & redirect));

  // Pending target as updated by this cycle's redirect, so a redirect that
  // lands on the releasing cycle is applied rather than lost. A branch may
  // not displace a parked flush.
  always_comb begin
    pend_nxt       = pend_pc;
    pend_flush_nxt = pend_flush;
    if (flush) begin
      pend_nxt       = target;
      pend_flush_nxt = 1'b1;
    end else if (redirect && !pend_flush) begin
      pend_nxt = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= DIS;
      pc         <= RESET_VEC;
      ce         <= ChipDisable;
      pend_pc    <= RESET_VEC;
      pend_flush <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        DIS: begin
          state <= RUN;
          ce    <= ChipEnable;
          pc    <= RESET_VEC;
        end
        RUN: begin
          misalign <= raw_misalign;
          if (redirect) begin
            if (req_valid && !req_ready) begin
              pend_pc    <= target;
              pend_flush <= flush;
              state      <= HOLD;
            end else begin
              pc <= target;
            end
          end else if (fire) begin
            pc <= pc + ADDR_W'(STEP);
          end
        end
        HOLD: begin
          misalign   <= raw_misalign;
          pend_pc    <= pend_nxt;
          pend_flush <= pend_flush_nxt;
          // Release on handshake or when a stall withdraws the request.
          if (!req_valid || req_ready) begin
            pc         <= pend_nxt;
            pend_flush <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= DIS;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        req_ready = 1'b0;
  logic [31:0] pc;
  logic        ce, req_valid, fetch_kill, misalign;

  int n_chk = 0;
  int n_fail = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_pc(branch_pc), .req_ready(req_ready),
    .pc(pc), .ce(ce), .req_valid(req_valid), .fetch_kill(fetch_kill),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: enabled flag, current pc, optional parked redirect.
  logic [31:0] m_pc = 32'h0, m_ppc = 32'h0;
  bit          m_ce = 0, m_en = 0, m_pend = 0, m_pflush = 0, m_mis = 0;
  bit          m_known = 0;
  bit          obs_valid, obs_kill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model, wait edge.
  task automatic cyc(input bit r, input bit st, input bit f, input logic [31:0] fp,
                     input bit b, input logic [31:0] bp, input bit rdy);
    bit rv, fire, hf, hb, redir;
    logic [31:0] raw, tgt;
    rst = r; stall = {$urandom_range(0, 31), st}; flush = f; flush_pc = fp;
    branch_flag = b; branch_pc = bp; req_ready = rdy;
    @(negedge clk);
    hf = f; hb = b && !st; redir = hf || hb;
    raw = hf ? fp : bp; tgt = {raw[31:2], 2'b00};
    rv = m_ce && !st && m_en;
    fire = rv && rdy;
    obs_valid = req_valid; obs_kill = fetch_kill;
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("ce", {31'b0, ce}, {31'b0, m_ce});
      chk("req_valid", {31'b0, req_valid}, {31'b0, rv});
      chk("fetch_kill", {31'b0, fetch_kill}, {31'b0, fire && (m_pend || (m_en && redir))});
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    end
    if (r) begin
      m_pc = 32'h0; m_ce = 0; m_en = 0; m_pend = 0; m_pflush = 0; m_mis = 0; m_known = 1;
    end else if (!m_en) begin
      m_en = 1; m_ce = 1; m_mis = 0;
    end else begin
      m_mis = redir && (raw[1:0] != 2'b00);
      if (m_pend) begin
        if (hf) begin m_ppc = tgt; m_pflush = 1; end
        else if (hb && !m_pflush) m_ppc = tgt;
        if (fire || !rv) begin m_pc = m_ppc; m_pend = 0; m_pflush = 0; end
      end else if (redir) begin
        if (rv && !rdy) begin m_pend = 1; m_ppc = tgt; m_pflush = hf; end
        else m_pc = tgt;
      end else if (fire) begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1, t2;
    bit r, st, f, b, rdy;
    @(posedge clk); #1;
    // Reset release and sequential fetch
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", {31'b0, ce}, 32'h0);
    run(1);
    chk("dis_valid", {31'b0, obs_valid}, 32'h0);
    chk("ce_on", {31'b0, ce}, 32'h1);
    chk("pc0", pc, 32'h0);
    run(1); chk("pc4", pc, 32'h4);
    run(1); chk("pc8", pc, 32'h8);
    run(1); run(1); chk("pc10", pc, 32'h10);
    // Backpressure
    repeat (4) begin
      run(0);
      chk("bp_pc", pc, 32'h10);
      chk("bp_valid", {31'b0, obs_valid}, 32'h1);
    end
    run(1); chk("bp_release", pc, 32'h14);
    repeat (3) run(1);
    chk("pc20", pc, 32'h20);
    // Redirect during wait
    cyc(0, 0, 0, 0, 1, 32'h100, 0); chk("hold_pc", pc, 32'h20);
    run(0); chk("hold_pc2", pc, 32'h20);
    run(1);
    chk("hold_kill", {31'b0, obs_kill}, 32'h1);
    chk("hold_target", pc, 32'h100);
    // Priority
    cyc(0, 0, 1, 32'h180, 1, 32'h200, 1);
    chk("prio_pc", pc, 32'h180);
    chk("prio_kill", {31'b0, obs_kill}, 32'h1);
    cyc(0, 1, 0, 0, 1, 32'h300, 1);
    chk("stall_br_pc", pc, 32'h180);
    // Alignment
    cyc(0, 0, 0, 0, 1, 32'h103, 1);
    chk("align_pc", pc, 32'h100);
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    run(0);
    chk("mis_end", {31'b0, misalign}, 32'h0);
    // Wrap
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    run(1); chk("wrap", pc, 32'h0);
    // Reset mid-HOLD
    cyc(0, 0, 0, 0, 1, 32'h400, 0); chk("h2_pc", pc, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("h2_rst_pc", pc, 32'h0);
    chk("h2_rst_ce", {31'b0, ce}, 32'h0);
    run(1); chk("h2_dis_pc", pc, 32'h0);
    run(1); chk("h2_seq", pc, 32'h4);
    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 19) == 0);
      b   = ($urandom_range(0, 6) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      t1 = $urandom; t2 = $urandom;
      if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) t2[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t2 = 32'hFFFF_FFF0 | (t2 & 32'hF);
      cyc(r, st, f, t1, b, t2, rdy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
